// File: rtl/ex_ctrl_pkg.sv
// Shared types and helpers for the EX-stage divide issue controller.
// Holds the ALU function codes the controller decodes, the divide FSM state
// type, fixed result constants and small decode helper functions.
package ex_ctrl_pkg;

    // ALU function codes (mirror of the sys_defs.vh encoding used by ID)
    localparam logic [4:0] ALU_ADD  = 5'h00;
    localparam logic [4:0] ALU_DIV  = 5'h10;
    localparam logic [4:0] ALU_DIVU = 5'h11;
    localparam logic [4:0] ALU_REM  = 5'h12;
    localparam logic [4:0] ALU_REMU = 5'h13;

    // Result reported when the watchdog gives up on the divider
    localparam logic [31:0] WDOG_RESULT = 32'hBAAD_BEEF;
    // RV32M fixed results
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN     = 32'h8000_0000;
    localparam logic [31:0] MINUS_ONE   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_func(input logic [4:0] func);
        return (func == ALU_DIV) || (func == ALU_DIVU) ||
               (func == ALU_REM) || (func == ALU_REMU);
    endfunction

    function automatic logic is_signed_func(input logic [4:0] func);
        return (func == ALU_DIV) || (func == ALU_REM);
    endfunction

    function automatic logic is_rem_func(input logic [4:0] func);
        return (func == ALU_REM) || (func == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry quotient/remainder cache keyed on {dividend, divisor, signedness}.
// Latency: lookup is combinational; a write is visible the cycle after wr_en.
// Backpressure: none; written only when the divider reports completion.
// Ports: clk/rst (sync, active-high clears the valid bit), wr_* write port,
//        rd_* lookup tag, hit/hit_q/hit_r lookup result.
module div_result_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_opa,
    input  logic [31:0] wr_opb,
    input  logic        wr_sgn,
    input  logic [31:0] wr_q,
    input  logic [31:0] wr_r,
    input  logic [31:0] rd_opa,
    input  logic [31:0] rd_opb,
    input  logic        rd_sgn,
    output logic        hit,
    output logic [31:0] hit_q,
    output logic [31:0] hit_r
);

    logic        c_vld;
    logic [31:0] c_opa;
    logic [31:0] c_opb;
    logic        c_sgn;
    logic [31:0] c_q;
    logic [31:0] c_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_vld <= 1'b0;
            c_opa <= '0;
            c_opb <= '0;
            c_sgn <= 1'b0;
            c_q   <= '0;
            c_r   <= '0;
        end else if (wr_en) begin
            c_vld <= 1'b1;
            c_opa <= wr_opa;
            c_opb <= wr_opb;
            c_sgn <= wr_sgn;
            c_q   <= wr_q;
            c_r   <= wr_r;
        end
    end

    // Sign is part of the tag: DIV and DIVU on the same bits differ
    assign hit   = c_vld && (rd_opa == c_opa) && (rd_opb == c_opb) && (rd_sgn == c_sgn);
    assign hit_q = c_q;
    assign hit_r = c_r;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage divide sequencer: launches the iterative divider, resolves RV32M
// corner cases and cache hits in the same cycle, and freezes the front end.
// Latency: special/hit 0 cycles; miss = divider latency + 1; DONE holds on mem_stall.
// Ports: clk/rst (sync active-high), ID/EX request (id_ex_vld, id_ex_alu_func, opa, opb),
//        flush/mem_stall, divider handshake (div_start/signed/opa/opb/kill, div_done/quotient/remainder),
//        EX result (ex_stall, ex_res_vld, ex_res) and sticky ex_wdog_err.
module div_issue_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_ex_vld,
    input  logic [4:0]  id_ex_alu_func,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    input  logic        mem_stall,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_kill,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        ex_stall,
    output logic        ex_res_vld,
    output logic [31:0] ex_res,
    output logic        ex_wdog_err
);

    div_state_t  state, state_nxt;
    logic [CNT_W-1:0] run_cnt;
    logic [31:0] lat_opa, lat_opb;
    logic        lat_sgn, lat_rem;
    logic [31:0] res_reg, res_nxt;
    logic        res_load;
    logic        wdog_err, err_set;
    logic        cache_wr;

    logic        is_div, sgn, want_rem;
    logic        by_zero, overflow;
    logic        hit;
    logic [31:0] hit_q, hit_r;

    assign is_div   = id_ex_vld && is_div_func(id_ex_alu_func);
    assign sgn      = is_signed_func(id_ex_alu_func);
    assign want_rem = is_rem_func(id_ex_alu_func);
    assign by_zero  = (opb == '0);
    assign overflow = sgn && (opa == INT_MIN) && (opb == MINUS_ONE);

    div_result_cache u_cache (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (cache_wr),
        .wr_opa (lat_opa),
        .wr_opb (lat_opb),
        .wr_sgn (lat_sgn),
        .wr_q   (div_quotient),
        .wr_r   (div_remainder),
        .rd_opa (opa),
        .rd_opb (opb),
        .rd_sgn (sgn),
        .hit    (hit),
        .hit_q  (hit_q),
        .hit_r  (hit_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            run_cnt  <= '0;
            lat_opa  <= '0;
            lat_opb  <= '0;
            lat_sgn  <= 1'b0;
            lat_rem  <= 1'b0;
            res_reg  <= '0;
            wdog_err <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter only meaningful in RUN; cleared everywhere else so a new launch starts at 0
            run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
            if (div_start) begin
                lat_opa <= opa;
                lat_opb <= opb;
                lat_sgn <= sgn;
                lat_rem <= want_rem;
            end
            if (res_load) begin
                res_reg <= res_nxt;
            end
            if (err_set) begin
                wdog_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        div_start  = 1'b0;
        div_kill   = 1'b0;
        ex_stall   = 1'b0;
        ex_res_vld = 1'b0;
        ex_res     = '0;
        cache_wr   = 1'b0;
        res_load   = 1'b0;
        res_nxt    = '0;
        err_set    = 1'b0;

        case (state)
            IDLE: begin
                if (is_div && !flush) begin
                    if (by_zero) begin
                        ex_res_vld = 1'b1;
                        ex_res     = want_rem ? opa : DIV0_QUOT;
                    end else if (overflow) begin
                        ex_res_vld = 1'b1;
                        ex_res     = want_rem ? 32'h0 : INT_MIN;
                    end else if (hit) begin
                        ex_res_vld = 1'b1;
                        ex_res     = want_rem ? hit_r : hit_q;
                    end else begin
                        div_start = 1'b1;
                        ex_stall  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                ex_stall = 1'b1;
                if (div_done) begin
                    // The divider result is valid even if the instruction is flushed
                    cache_wr = 1'b1;
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        res_load  = 1'b1;
                        res_nxt   = lat_rem ? div_remainder : div_quotient;
                        state_nxt = DONE;
                    end
                end else if (flush) begin
                    div_kill  = 1'b1;
                    state_nxt = IDLE;
                end else if (run_cnt == CNT_W'(WDOG_LIMIT - 1)) begin
                    div_kill  = 1'b1;
                    err_set   = 1'b1;
                    res_load  = 1'b1;
                    res_nxt   = WDOG_RESULT;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    ex_res_vld = 1'b1;
                    ex_res     = res_reg;
                    if (!mem_stall) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Divider shares rst, so no kill pulse or result is emitted while in reset
        if (rst) begin
            div_start  = 1'b0;
            div_kill   = 1'b0;
            ex_stall   = 1'b0;
            ex_res_vld = 1'b0;
            ex_res     = '0;
            cache_wr   = 1'b0;
            res_load   = 1'b0;
            err_set    = 1'b0;
        end
    end

    // Launch cycle forwards live operands; afterwards the latched copy is held
    assign div_signed  = div_start ? sgn : lat_sgn;
    assign div_opa     = div_start ? opa : lat_opa;
    assign div_opb     = div_start ? opb : lat_opb;
    assign ex_wdog_err = wdog_err;

endmodule
